// File: rtl/kernel_loader_if.sv
// Byte-stream valid/ready link carrying kernel upload frames into kernel_loader.
// A byte transfers on the clock edge where in_valid and in_ready are both high.
interface kernel_loader_if;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;

   modport master (output in_data, output in_valid, input in_ready);
   modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/kernel_loader.sv
// Parses framed 5x5 kernel uploads into shadow registers, then commits them atomically after checksum check.
// Result pulses one cycle after the CSUM byte; in_ready drops only for that single COMMIT cycle.
module kernel_loader #(
   parameter int         N   = 25,
   parameter int         KW  = 8,
   parameter int         DW  = 4,
   parameter logic [7:0] HDR = 8'hA5
) (
   input  logic              clk,
   input  logic              rst_n,
   kernel_loader_if.slave    s,
   output logic [N*KW-1:0]   kernel,
   output logic [DW-1:0]     div,
   output logic              busy,
   output logic              load_done,
   output logic              load_err
);
   localparam int IW = $clog2(N);
   localparam logic [N*KW-1:0] PASS = (N*KW)'(1) << ((N - 1 - N/2) * KW);

   typedef enum logic [2:0] {IDLE, COEF, DIVS, CSUM, COMMIT} state_t;

   state_t          state, state_nxt;
   logic [IW-1:0]   idx;
   logic [7:0]      xr;
   logic [KW-1:0]   shadow [N];
   logic [7:0]      shadow_div;
   logic            ok;
   logic            accept;
   logic [N*KW-1:0] shadow_flat;

   assign accept = s.in_valid && s.in_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept && s.in_data == HDR) state_nxt = COEF;
         COEF:    if (accept && idx == IW'(N-1))  state_nxt = DIVS;
         DIVS:    if (accept)                     state_nxt = CSUM;
         CSUM:    if (accept)                     state_nxt = COMMIT;
         COMMIT:                                  state_nxt = IDLE;
         default:                                 state_nxt = IDLE;
      endcase
   end

   always_comb begin
      s.in_ready = (state != COMMIT);
      busy       = (state != IDLE);
   end

   // Coefficient 0 lands in the most significant byte of the flat bus.
   always_comb begin
      shadow_flat = '0;
      for (int i = 0; i < N; i++)
         shadow_flat[(N-1-i)*KW +: KW] = shadow[i];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idx        <= '0;
         xr         <= '0;
         shadow_div <= '0;
         ok         <= 1'b0;
         kernel     <= PASS;
         div        <= '0;
         load_done  <= 1'b0;
         load_err   <= 1'b0;
         for (int i = 0; i < N; i++) shadow[i] <= '0;
      end else begin
         load_done <= 1'b0;
         load_err  <= 1'b0;
         case (state)
            IDLE: begin
               if (accept && s.in_data == HDR) begin
                  idx <= '0;
                  xr  <= '0;
               end
            end
            COEF: begin
               if (accept) begin
                  shadow[idx] <= s.in_data;
                  xr          <= xr ^ s.in_data;
                  idx         <= idx + 1'b1;
               end
            end
            DIVS: begin
               if (accept) begin
                  shadow_div <= s.in_data;
                  xr         <= xr ^ s.in_data;
               end
            end
            CSUM: begin
               // A divisor byte wider than DW bits is rejected even with a good checksum.
               if (accept)
                  ok <= (s.in_data == xr) && (shadow_div[7:DW] == '0);
            end
            COMMIT: begin
               if (ok) begin
                  kernel    <= shadow_flat;
                  div       <= shadow_div[DW-1:0];
                  load_done <= 1'b1;
               end else begin
                  load_err  <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end
endmodule
